// File: rtl/line_follow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : line_follow_sequencer
//  Purpose  : Mode controller for the line-follower robot. It samples the
//             three filtered sensor bits every cycle and sequences the robot
//             through these modes:
//               - normal line tracking
//               - a lost-line grace period
//               - a two-direction spin search
//               - a timed straight crossing of intersections
//               - a latched fault
//             It drives the speed/direction commands of the two PWM motor
//             channels and counts intersections crossed.
//
//  Ports    : clk          system clock, all state changes on posedge
//             rst          asynchronous active-high reset
//             enable       run request; low forces IDLE
//             sensors[2:0] {left,middle,right}; 0 = line under that sensor
//             left_speed   left PWM duty command (registered)
//             right_speed  right PWM duty command (registered)
//             dirL, dirR   wheel directions, 1 = forward (registered)
//             state[2:0]   current state encoding
//             xcount[7:0]  intersections crossed, saturating at 255
//             fault        high while in FAULT
//
//  Revision : 1.0  initial release
// ============================================================================
module line_follow_sequencer #(
  parameter logic [7:0]  MAX           = 8'd15,
  parameter logic [7:0]  HALF          = 8'd3,
  parameter logic [15:0] LOST_CYCLES   = 16'd1000,
  parameter logic [15:0] SEARCH_CYCLES = 16'd2000,
  parameter logic [15:0] CROSS_CYCLES  = 16'd500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] sensors,
  output logic [7:0] left_speed,
  output logic [7:0] right_speed,
  output logic       dirL,
  output logic       dirR,
  output logic [2:0] state,
  output logic [7:0] xcount,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FOLLOW    = 3'd1,
    ST_LOST_WAIT = 3'd2,
    ST_SEARCH    = 3'd3,
    ST_CROSS     = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // Search progress. The second sweep lasts two SEARCH_CYCLES periods; it is
  // split into two halves so every timeout stays a 16-bit equality on cnt,
  // even when 2*SEARCH_CYCLES would not fit in the counter.
  typedef enum logic [1:0] {
    PH_FIRST   = 2'd0,
    PH_SECOND0 = 2'd1,
    PH_SECOND1 = 2'd2
  } phase_t;

  localparam logic [2:0] ALL_WHITE = 3'b111;
  localparam logic [2:0] ALL_BLACK = 3'b000;

  state_t      cur_state, nxt_state;
  phase_t      phase, phase_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        last_side, last_side_nxt;
  logic        sweep, sweep_nxt;
  logic [7:0]  lspd_nxt, rspd_nxt;
  logic        dirl_nxt, dirr_nxt;
  logic [7:0]  xcount_nxt;
  logic        fault_nxt;

  // Steering decode of the sampled pattern. steer_hit is low for the two
  // patterns (all white / all black) that carry no steering information; in
  // that case FOLLOW keeps whatever speeds were last commanded.
  logic        steer_hit;
  logic [7:0]  steer_l, steer_r;
  logic        side_set, side_val;

  always_comb begin
    steer_hit = 1'b1;
    steer_l   = MAX;
    steer_r   = MAX;
    side_set  = 1'b0;
    side_val  = 1'b0;
    case (sensors)
      3'b101: begin end                 // centred
      3'b010: begin end                 // middle-only white: glitch, ignored
      3'b001: begin steer_l = HALF;  side_set = 1'b1; side_val = 1'b0; end
      3'b011: begin steer_l = 8'd0;  side_set = 1'b1; side_val = 1'b0; end
      3'b100: begin steer_r = HALF;  side_set = 1'b1; side_val = 1'b1; end
      3'b110: begin steer_r = 8'd0;  side_set = 1'b1; side_val = 1'b1; end
      default: steer_hit = 1'b0;
    endcase
  end

  // Next-state logic. Outputs are derived from the state being entered, so
  // the registered outputs always match the state register after each edge.
  always_comb begin
    nxt_state     = cur_state;
    phase_nxt     = phase;
    cnt_nxt       = cnt + 16'd1;
    last_side_nxt = last_side;
    sweep_nxt     = sweep;
    lspd_nxt      = left_speed;
    rspd_nxt      = right_speed;
    dirl_nxt      = dirL;
    dirr_nxt      = dirR;
    xcount_nxt    = xcount;

    if (!enable) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE: nxt_state = ST_FOLLOW;

        ST_FOLLOW: begin
          if (sensors == ALL_WHITE) begin
            nxt_state = ST_LOST_WAIT;
          end else if (sensors == ALL_BLACK) begin
            nxt_state = ST_CROSS;
            if (xcount != 8'hFF) xcount_nxt = xcount + 8'd1;
          end
        end

        // Reacquisition is tested before the timeout so it wins a tie.
        ST_LOST_WAIT: begin
          if (sensors != ALL_WHITE) begin
            nxt_state = ST_FOLLOW;
          end else if (cnt == LOST_CYCLES - 16'd1) begin
            nxt_state = ST_SEARCH;
            sweep_nxt = last_side;
            phase_nxt = PH_FIRST;
          end
        end

        ST_SEARCH: begin
          if (sensors != ALL_WHITE) begin
            nxt_state = ST_FOLLOW;
          end else if (cnt == SEARCH_CYCLES - 16'd1) begin
            case (phase)
              PH_FIRST: begin
                sweep_nxt = ~sweep;
                phase_nxt = PH_SECOND0;
                cnt_nxt   = 16'd0;
              end
              PH_SECOND0: begin
                phase_nxt = PH_SECOND1;
                cnt_nxt   = 16'd0;
              end
              default: nxt_state = ST_FAULT;
            endcase
          end
        end

        ST_CROSS: begin
          if (cnt == CROSS_CYCLES - 16'd1) nxt_state = ST_FOLLOW;
        end

        ST_FAULT: nxt_state = ST_FAULT;

        default: nxt_state = ST_IDLE;
      endcase
    end

    // cnt restarts on every state entry and only runs in timed states.
    if ((nxt_state != cur_state) ||
        !((nxt_state == ST_LOST_WAIT) || (nxt_state == ST_SEARCH) ||
          (nxt_state == ST_CROSS))) begin
      cnt_nxt = 16'd0;
    end

    case (nxt_state)
      ST_FOLLOW: begin
        dirl_nxt = 1'b1;
        dirr_nxt = 1'b1;
        if (steer_hit) begin
          lspd_nxt = steer_l;
          rspd_nxt = steer_r;
        end
        if (side_set) last_side_nxt = side_val;
      end
      ST_LOST_WAIT: begin
        // coast on the last steering command
      end
      ST_SEARCH: begin
        // spin in place: sweep=0 turns left, sweep=1 turns right
        lspd_nxt = HALF;
        rspd_nxt = HALF;
        dirl_nxt = sweep_nxt;
        dirr_nxt = ~sweep_nxt;
      end
      ST_CROSS: begin
        lspd_nxt = MAX;
        rspd_nxt = MAX;
        dirl_nxt = 1'b1;
        dirr_nxt = 1'b1;
      end
      default: begin                    // IDLE and FAULT: motors stopped
        lspd_nxt = 8'd0;
        rspd_nxt = 8'd0;
        dirl_nxt = 1'b1;
        dirr_nxt = 1'b1;
      end
    endcase

    fault_nxt = (nxt_state == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= ST_IDLE;
      phase       <= PH_FIRST;
      cnt         <= 16'd0;
      last_side   <= 1'b0;
      sweep       <= 1'b0;
      left_speed  <= 8'd0;
      right_speed <= 8'd0;
      dirL        <= 1'b1;
      dirR        <= 1'b1;
      xcount      <= 8'd0;
      fault       <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      phase       <= phase_nxt;
      cnt         <= cnt_nxt;
      last_side   <= last_side_nxt;
      sweep       <= sweep_nxt;
      left_speed  <= lspd_nxt;
      right_speed <= rspd_nxt;
      dirL        <= dirl_nxt;
      dirR        <= dirr_nxt;
      xcount      <= xcount_nxt;
      fault       <= fault_nxt;
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_line_follow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_follow_sequencer
//  Purpose  : Self-checking bench for line_follow_sequencer. Directed
//             sequences plus randomized sensor runs, all compared against a
//             behavioural model that tracks time-in-state.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_follow_sequencer;

  localparam int L = 4;
  localparam int S = 8;
  localparam int C = 3;
  localparam int MAXV = 15;
  localparam int HALFV = 3;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] sensors;
  logic [7:0] left_speed, right_speed;
  logic       dirL, dirR;
  logic [2:0] state;
  logic [7:0] xcount;
  logic       fault;

  int tests = 0;
  int fails = 0;

  line_follow_sequencer #(
    .MAX(8'd15), .HALF(8'd3),
    .LOST_CYCLES(16'd4), .SEARCH_CYCLES(16'd8), .CROSS_CYCLES(16'd3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensors(sensors),
    .left_speed(left_speed), .right_speed(right_speed),
    .dirL(dirL), .dirR(dirR), .state(state), .xcount(xcount), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t = edges spent in the current state; search direction is derived
  // from total elapsed search time rather than a sweep register.
  int m_state, m_t, m_l, m_r, m_dl, m_dr, m_x, m_fault, m_last, m_sweep0;

  task automatic model_reset();
    m_state = 0; m_t = 0; m_l = 0; m_r = 0; m_dl = 1; m_dr = 1;
    m_x = 0; m_fault = 0; m_last = 0; m_sweep0 = 0;
  endtask

  task automatic model_step(input logic en, input logic [2:0] s);
    int ns, tn, sw;
    ns = m_state;
    if (!en) ns = 0;
    else begin
      case (m_state)
        0: ns = 1;
        1: if (s == 3'b111) ns = 2;
           else if (s == 3'b000) begin ns = 4; if (m_x < 255) m_x = m_x + 1; end
        2: if (s != 3'b111) ns = 1;
           else if (m_t == L - 1) begin ns = 3; m_sweep0 = m_last; end
        3: if (s != 3'b111) ns = 1;
           else if (m_t == 3 * S - 1) ns = 5;
        4: if (m_t == C - 1) ns = 1;
        5: ns = 5;
        default: ns = 0;
      endcase
    end
    tn = (ns == m_state) ? m_t + 1 : 0;
    case (ns)
      1: begin
        m_dl = 1; m_dr = 1;
        case (s)
          3'b101, 3'b010: begin m_l = MAXV;  m_r = MAXV; end
          3'b001: begin m_l = HALFV; m_r = MAXV;  m_last = 0; end
          3'b011: begin m_l = 0;     m_r = MAXV;  m_last = 0; end
          3'b100: begin m_l = MAXV;  m_r = HALFV; m_last = 1; end
          3'b110: begin m_l = MAXV;  m_r = 0;     m_last = 1; end
          default: begin end
        endcase
      end
      2: begin end
      3: begin
        sw = (tn < S) ? m_sweep0 : 1 - m_sweep0;
        m_l = HALFV; m_r = HALFV; m_dl = sw; m_dr = 1 - sw;
      end
      4: begin m_l = MAXV; m_r = MAXV; m_dl = 1; m_dr = 1; end
      default: begin m_l = 0; m_r = 0; m_dl = 1; m_dr = 1; end
    endcase
    m_fault = (ns == 5) ? 1 : 0;
    m_state = ns;
    m_t = tn;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".state"}, state, m_state);
    check({tag, ".lspd"}, left_speed, m_l);
    check({tag, ".rspd"}, right_speed, m_r);
    check({tag, ".dirL"}, dirL, m_dl);
    check({tag, ".dirR"}, dirR, m_dr);
    check({tag, ".xcount"}, xcount, m_x);
    check({tag, ".fault"}, fault, m_fault);
  endtask

  task automatic cycle(input logic en, input logic [2:0] s);
    enable = en;
    sensors = s;
    @(posedge clk);
    model_step(en, s);
    #1;
    compare_all("mdl");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".state"}, state, 0);
    check({tag, ".lspd"}, left_speed, 0);
    check({tag, ".rspd"}, right_speed, 0);
    check({tag, ".dirL"}, dirL, 1);
    check({tag, ".dirR"}, dirR, 1);
    check({tag, ".xcount"}, xcount, 0);
    check({tag, ".fault"}, fault, 0);
  endtask

  logic [2:0] pats [6] = '{3'b101, 3'b001, 3'b011, 3'b100, 3'b110, 3'b010};
  int         exp_l [6] = '{15, 3, 0, 15, 15, 15};
  int         exp_r [6] = '{15, 15, 15, 3, 0, 15};

  initial begin
    int len, pick;
    logic [2:0] pat;
    logic en;

    rst = 1'b1; enable = 1'b0; sensors = 3'b101;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // reset / enable
    cycle(1'b1, 3'b101);
    check("en.state", state, 1);
    cycle(1'b1, 3'b101);
    check("en.lspd", left_speed, 15);
    check("en.rspd", right_speed, 15);
    check("en.dirs", {dirL, dirR}, 2'b11);
    cycle(1'b0, 3'b101);
    check("dis.state", state, 0);
    check("dis.lspd", left_speed, 0);

    // steering table
    cycle(1'b1, 3'b101);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, pats[i]);
      check("steer.l", left_speed, exp_l[i]);
      check("steer.r", right_speed, exp_r[i]);
      cycle(1'b1, pats[i]);
    end

    // lost, then recover mid-search
    cycle(1'b1, 3'b110);
    cycle(1'b1, 3'b111);
    check("lost.state", state, 2);
    check("lost.hold", {left_speed, right_speed}, {8'd15, 8'd0});
    repeat (4) cycle(1'b1, 3'b111);
    check("srch.state", state, 3);
    check("srch.dirs", {dirL, dirR}, 2'b10);
    check("srch.spd", {left_speed, right_speed}, {8'd3, 8'd3});
    cycle(1'b1, 3'b111);
    cycle(1'b1, 3'b101);
    check("reacq.state", state, 1);
    check("reacq.spd", {left_speed, right_speed}, {8'd15, 8'd15});

    // search exhaustion
    cycle(1'b1, 3'b011);
    cycle(1'b1, 3'b111);
    repeat (4) cycle(1'b1, 3'b111);
    check("exh.state", state, 3);
    check("exh.left", {dirL, dirR}, 2'b01);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 3'b111);
      check("exh.spinL", {dirL, dirR}, 2'b01);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 3'b111);
      check("exh.spinR", {state, dirL, dirR}, {3'd3, 2'b10});
    end
    cycle(1'b1, 3'b111);
    check("exh.fault", {state, fault}, {3'd5, 1'b1});
    check("exh.spd", {left_speed, right_speed}, 16'd0);
    repeat (3) cycle(1'b1, 3'b101);
    check("fault.latch", state, 5);
    cycle(1'b0, 3'b101);
    check("fault.clr", {state, fault}, {3'd0, 1'b0});

    // intersections with saturation
    cycle(1'b1, 3'b101);
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 3'b000);
      check("x.state", state, 4);
      check("x.count", xcount, (i < 255) ? i + 1 : 255);
      repeat (2) begin
        cycle(1'b1, 3'b101);
        check("x.hold", {state, left_speed, right_speed}, {3'd4, 8'd15, 8'd15});
      end
      cycle(1'b1, 3'b101);
      check("x.exit", state, 1);
    end
    check("x.sat", xcount, 255);

    // reacquisition beats lost timeout
    cycle(1'b1, 3'b111);
    repeat (3) cycle(1'b1, 3'b111);
    cycle(1'b1, 3'b101);
    check("tie.lost", state, 1);

    // enable=0 beats cross timeout
    cycle(1'b1, 3'b000);
    repeat (2) cycle(1'b1, 3'b101);
    cycle(1'b0, 3'b101);
    check("tie.en", state, 0);

    // asynchronous reset mid-search
    cycle(1'b1, 3'b101);
    repeat (7) cycle(1'b1, 3'b111);
    check("pre.rst", state, 3);
    #1 rst = 1'b1;
    #1;
    check_reset_values("arst");
    model_reset();
    #1 rst = 1'b0;

    // randomized runs
    for (int seg = 0; seg < 250; seg++) begin
      len = $urandom_range(1, 30);
      pick = $urandom_range(0, 9);
      if (pick < 4) pat = 3'b111;
      else if (pick == 4) pat = 3'b000;
      else pat = 3'($urandom_range(0, 7));
      for (int k = 0; k < len; k++) begin
        en = ($urandom_range(0, 63) != 0);
        cycle(en, pat);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
